// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and ALU-control encodings shared by the multicycle control unit
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;
  typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR, C_BAD} op_class_e;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  function automatic op_class_e classify(input logic [6:0] op, input logic [2:0] f3);
    return op == OP_R ? C_R :
           op == OP_I ? C_I :
           (op == OP_LD && f3 == F3_WORD) ? C_LD :
           (op == OP_ST && f3 == F3_WORD) ? C_ST :
           op == OP_BR ? C_BR : C_BAD;
  endfunction
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: maps instruction class, funct3 and funct7[5] to the ALU operation code
module alu_ctrl_dec
  import ctrl_pkg::*;
(
  input  op_class_e  cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] aluctr
);
  logic [3:0] logic_op;
  logic       is_sub;
  assign logic_op = funct3 == 3'b111 ? ALU_AND : funct3 == 3'b110 ? ALU_OR : ALU_ADD;
  assign is_sub   = cls == C_BR || (cls == C_R && funct3 == 3'b000 && funct7b5);
  assign aluctr   = is_sub ? ALU_SUB : (cls == C_R || cls == C_I) ? logic_op : ALU_ADD;
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multicycle RV32I control FSM with retired counter and sticky illegal trap
module riscv_multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUCTR_W      = 4,
  parameter int CNT_W         = 16,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alusrc,
  output logic                regwrite,
  output logic                memtoreg,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);
  state_e     st, nxt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  op_class_e  cls;
  logic [3:0] dec_alu;
  logic       done, retire;
  assign cls   = classify(opcode, funct3);
  assign done  = rst_n && (MEM_HANDSHAKE == 0 || mem_ready);
  assign state = st;
  assign ALUctr = ALUCTR_W'(st == S_EXEC ? dec_alu : ALU_ADD);
  alu_ctrl_dec u_dec (
    .cls      (cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .aluctr   (dec_alu)
  );
  // state register, instruction field capture, sticky trap flag and saturating retire counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= S_FETCH;
      opcode   <= '0;
      funct3   <= '0;
      funct7b5 <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      st <= nxt;
      if (ir_write) begin
        opcode   <= instr[6:0];
        funct3   <= instr[14:12];
        funct7b5 <= instr[30];
      end
      if (st == S_DECODE && cls == C_BAD) illegal <= 1'b1;
      if (retire && retired != '1) retired <= retired + CNT_W'(1);
    end
  // next state and per-state datapath enables; done folds in rst_n so enables drop with reset
  always_comb begin
    nxt      = st;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    retire   = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = done;
        pc_write = done;
        nxt      = done ? S_DECODE : S_FETCH;
      end
      S_DECODE: nxt = cls == C_BAD ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alusrc   = cls == C_I || cls == C_LD || cls == C_ST;
        pc_write = cls == C_BR && zero;
        pc_src   = cls == C_BR;
        retire   = cls == C_BR;
        nxt      = cls == C_BR ? S_FETCH : (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = cls == C_ST;
        retire  = done && cls == C_ST;
        nxt     = !done ? S_MEM : cls == C_ST ? S_FETCH : S_WB;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = cls == C_LD;
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: randomized instruction stream checked against a per-instruction cycle script
module tb_riscv_multicycle_ctrl;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_BAD = 5;
  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000, A_OR = 4'b0001;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc, regwrite, memtoreg, illegal;
  logic [3:0] alu;
  logic [2:0] state;
  logic [15:0] retired;
  logic s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_src, s_alusrc, s_regwrite, s_memtoreg, s_illegal;
  logic [3:0] s_alu;
  logic [2:0] s_state;
  logic [1:0] s_retired;
  logic [15:0] ov, sov;
  int checks = 0, errors = 0, n_ret = 0;

  riscv_multicycle_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alusrc(alusrc), .regwrite(regwrite), .memtoreg(memtoreg), .ALUctr(alu),
    .state(state), .illegal(illegal), .retired(retired)
  );
  riscv_multicycle_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord), .ir_write(s_ir_write), .pc_write(s_pc_write),
    .pc_src(s_pc_src), .alusrc(s_alusrc), .regwrite(s_regwrite), .memtoreg(s_memtoreg), .ALUctr(s_alu),
    .state(s_state), .illegal(s_illegal), .retired(s_retired)
  );
  assign ov  = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc, regwrite, memtoreg, alu};
  assign sov = {s_state, s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_src, s_alusrc, s_regwrite, s_memtoreg, s_alu};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ev(input logic [2:0] st, input bit req, input bit we, input bit io,
                                     input bit irw, input bit pcw, input bit pcs, input bit als,
                                     input bit rw, input bit m2r, input logic [3:0] a);
    return {st, req, we, io, irw, pcw, pcs, als, rw, m2r, a};
  endfunction

  function automatic int kind(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    case (i[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return f3 == 3'b010 ? K_LW : K_BAD;
      7'b0100011: return f3 == 3'b010 ? K_SW : K_BAD;
      7'b1100011: return K_BR;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] i);
    int k;
    logic [2:0] f3;
    k  = kind(i);
    f3 = i[14:12];
    if (k == K_BR) return A_SUB;
    if (k == K_R && f3 == 3'b000) return i[30] ? A_SUB : A_ADD;
    if (k == K_R || k == K_I) return f3 == 3'b111 ? A_AND : f3 == 3'b110 ? A_OR : A_ADD;
    return A_ADD;
  endfunction

  function automatic logic [31:0] gen(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_R:  r[6:0] = 7'b0110011;
      K_I:  r[6:0] = 7'b0010011;
      K_LW: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
      K_SW: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
      default: r[6:0] = 7'b1100011;
    endcase
    return r;
  endfunction

  task automatic step(input string tag, input logic [15:0] e, input bit mr, input bit z);
    mem_ready = mr;
    zero = z;
    #2;
    check(tag, 32'(ov), 32'(e));
    check({tag, "/sat"}, 32'(sov), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] ins, input int wf, input int wm, input bit z);
    int k;
    logic [3:0] a;
    k = kind(ins);
    a = ref_alu(ins);
    instr = ins;
    repeat (wf) step("fetch_wait", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 0, 1'($urandom));
    step("fetch", ev(3'd0, 1, 0, 0, 1, 1, 0, 0, 0, 0, A_ADD), 1, 1'($urandom));
    instr = $urandom;
    check("illegal_pre", 32'(illegal), 32'(0));
    step("decode", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'($urandom), 1'($urandom));
    if (k == K_BAD) begin
      repeat (10) step("trap", ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'($urandom), 1'($urandom));
      check("illegal", 32'(illegal), 32'(1));
      check("illegal/sat", 32'(s_illegal), 32'(1));
      check("trap_retired", 32'(retired), 32'(n_ret));
      return;
    end
    step("exec", ev(3'd2, 0, 0, 0, 0, k == K_BR && z, k == K_BR, k == K_I || k == K_LW || k == K_SW, 0, 0, a),
         1'($urandom), z);
    if (k == K_LW || k == K_SW) begin
      repeat (wm) step("mem_wait", ev(3'd3, 1, k == K_SW, 1, 0, 0, 0, 0, 0, 0, A_ADD), 0, 1'($urandom));
      step("mem", ev(3'd3, 1, k == K_SW, 1, 0, 0, 0, 0, 0, 0, A_ADD), 1, 1'($urandom));
    end
    if (k == K_R || k == K_I || k == K_LW)
      step("wb", ev(3'd4, 0, 0, 0, 0, 0, 0, 0, 1, k == K_LW, A_ADD), 1'($urandom), 1'($urandom));
    n_ret++;
    check("retired", 32'(retired), 32'(n_ret));
    check("retired_sat", 32'(s_retired), 32'(n_ret > 3 ? 3 : n_ret));
    check("illegal_clear", 32'(illegal), 32'(0));
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check("rst_vec", 32'(ov), 32'(ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD)));
    check("rst_vec/sat", 32'(sov), 32'(ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD)));
    check("rst_retired", 32'(retired), 32'(0));
    check("rst_retired/sat", 32'(s_retired), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    n_ret = 0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wf, wm, k;
    logic [31:0] ins;
    mem_ready = 1'b1;
    #3;
    check("por_vec", 32'(ov), 32'(ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD)));
    check("por_retired", 32'(retired), 32'(0));
    check("por_illegal", 32'(illegal), 32'(0));
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 0);
    run({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 0);
    run({12'd8, 5'd1, 3'b010, 5'd4, 7'b0000011}, 0, 2, 0);
    run({7'd0, 5'd4, 5'd1, 3'b010, 5'd8, 7'b0100011}, 0, 0, 0);
    run({7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 0, 0, 1);
    run({7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 0, 0, 0);
    run({12'd5, 5'd1, 3'b111, 5'd6, 7'b0010011}, 2, 0, 0);
    run({7'b0100000, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011}, 1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 4);
      ins = gen(k);
      wf  = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      wm  = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      run(ins, wf, wm, 1'($urandom));
    end
    instr = gen(K_LW);
    step("mid_fetch", ev(3'd0, 1, 0, 0, 1, 1, 0, 0, 0, 0, A_ADD), 1, 0);
    step("mid_decode", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 0, 0);
    step("mid_exec", ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0, A_ADD), 0, 0);
    step("mid_wait", ev(3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 0, A_ADD), 0, 0);
    do_reset();
    run({25'h1ffffff, 7'b1111111}, 0, 0, 0);
    do_reset();
    run({17'd0, 3'b000, 5'd1, 7'b0000011}, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) run(gen(K_I), 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
